motor_rodada: RTL
=================

# motor_rodada

Parametrised round engine for the LED memory game: fetches each expected pattern from an external synchronous pattern memory, blinks it on the LEDs, then waits for a button play under a per-move timeout. Each play is scored against the expected pattern, with an optional hard mode that rejects repeating the previous correct play. Generalises the fixed 4-button / 3-hit / 300-tick datapath and absorbs its control FSM. Sits between the pattern memories and the top-level display/LED muxes.

## Interface
- NBTN, 4: buttons and LEDs per pattern.
- SEQ_W, 4: address width; sequence depth 2^SEQ_W.
- TIMEOUT, 300: `tick` pulses allowed per move (≥1).
- BLINK_ON, 500: clock cycles LEDs lit per blink (≥1).
- BLINK_OFF, 500: clock cycles LEDs dark per blink (≥1).
- NPISCA, 3: blinks per pattern (≥1).
- NACERTOS, 3: hits needed to win (≥1).
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- iniciar  in  1  level; sampled in OCIOSO and FIM.
- nivel  in  1  0 = easy, 1 = hard; latched on round start.
- tick  in  1  one-cycle timer enable from the clock divider.
- botoes  in  NBTN  raw button levels, already synchronised.
- mem_addr  out  SEQ_W  pattern address.
- mem_data  in  NBTN  pattern; valid 1 cycle after mem_addr changes.
- leds  out  NBTN  displayed pattern.
- acertos  out  clog2(NACERTOS+1)  hit count.
- tempo_restante  out  clog2(TIMEOUT+1)  TIMEOUT minus ticks elapsed.
- fim_rodada, vitoria, timeout  out  1  end status, valid in FIM.
- db_estado  out  3  state encoding.

## Operation
- States: OCIOSO, CARREGA, MOSTRA, ESPERA, REGISTRA, COMPARA, FIM.
- Reset values: state OCIOSO; mem_addr 0; leds 0; acertos 0; tempo_restante TIMEOUT; fim_rodada, vitoria, timeout 0; jogada and acerto_anterior registers 0.
- OCIOSO, iniciar=1 → CARREGA: clear mem_addr, acertos, acerto_anterior and status outputs; latch nivel.
- CARREGA: stay 1 cycle, then capture mem_data into esperado → MOSTRA.
- MOSTRA: leds = esperado for BLINK_ON cycles, then 0 for BLINK_OFF cycles, repeated NPISCA times → ESPERA. Buttons are ignored.
- ESPERA: leds = 0; tempo_restante loads TIMEOUT on entry and decrements once per tick. A rising edge of |botoes → REGISTRA. tempo_restante reaching 0 → FIM with timeout=1 and vitoria=0.
- Rising-edge detect is based on the previous-cycle OR of botoes and is updated in every state. A button held through MOSTRA therefore does not fire on entering ESPERA.
- REGISTRA: jogada ← botoes (all bits, multi-press allowed) → COMPARA.
- COMPARA: hit when jogada == esperado and jogada != 0.
  - Hard mode additionally requires jogada != acerto_anterior.
  - On a hit: acertos+1 and acerto_anterior ← jogada.
  - If the new acertos == NACERTOS → FIM with vitoria=1.
  - Otherwise, if mem_addr == 2^SEQ_W−1 → FIM with vitoria=0 (the sequence never wraps).
  - Otherwise mem_addr+1 → CARREGA.
  - A miss does not change acertos.
- FIM: fim_rodada=1; status outputs and acertos are held. iniciar=1 → CARREGA as from OCIOSO.
- Simultaneous edge and final tick in the same ESPERA cycle: the edge wins, no timeout.
- reset at any point, including mid-blink or mid-wait, forces all reset values on the next edge.

## Timing
- Edge detection to REGISTRA: 1 cycle. REGISTRA to COMPARA: 1 cycle. Score visible on acertos and status outputs 1 cycle after COMPARA.
- Pattern to first lit LED: CARREGA takes 2 cycles; leds go high on the first MOSTRA cycle.
- MOSTRA lasts exactly NPISCA·(BLINK_ON+BLINK_OFF) cycles.
- Timeout fires on the cycle after the TIMEOUT-th tick seen in ESPERA.
- Counters saturate or are cleared; none wraps.

## Structure
- Package motor_rodada_pkg holds:
  - the state enum, 3-bit encoding in the order listed (OCIOSO=0);
  - width helper functions for acertos and tempo_restante.
- Sub-module contador_pisca implements the ON/OFF/count blink sequencer:
  - inputs: start, parameters BLINK_ON, BLINK_OFF, NPISCA;
  - outputs: aceso, fim.
- Edge detector, timer and compare logic stay inline.

## Test plan
- NBTN=4, BLINK_ON=2, BLINK_OFF=2, NPISCA=2, mem[0]=4'b0010: iniciar → leds 0010 for 2 cycles, 0 for 2, 0010 for 2, 0 for 2, then state ESPERA.
- Easy mode, mem = {0001, 0001, 0100}, correct presses each move, NACERTOS=3 → acertos 1, 2, 3; vitoria=1, fim_rodada=1; mem_addr stops at 2.
- Hard mode with the same memory and same presses → second play rejected, acertos stays 1 after move 2; third hit gives acertos=2.
- TIMEOUT=5, no press, ticks every 3 cycles → tempo_restante 5→0; timeout=1, vitoria=0, acertos unchanged.
- Button held through MOSTRA → no REGISTRA until release and re-press. Press on the same cycle as the 5th tick → scored, no timeout.
- reset asserted mid-MOSTRA and mid-ESPERA → next cycle OCIOSO, leds 0, acertos 0, tempo_restante=TIMEOUT.

Source files
------------

// File: rtl/motor_rodada_pkg.sv
// Shared definitions for the LED memory-game round engine: state encoding
// and the width helpers used to size the score and timer outputs.
package motor_rodada_pkg;

    // Round FSM state encoding, exported as-is on db_estado.
    typedef logic [2:0] estado_t;

    localparam estado_t OCIOSO   = 3'd0;
    localparam estado_t CARREGA  = 3'd1;
    localparam estado_t MOSTRA   = 3'd2;
    localparam estado_t ESPERA   = 3'd3;
    localparam estado_t REGISTRA = 3'd4;
    localparam estado_t COMPARA  = 3'd5;
    localparam estado_t FIM      = 3'd6;

    // Bits needed to hold a hit count from 0 up to nacertos.
    function automatic int largura_acertos(input int nacertos);
        return (nacertos > 0) ? $clog2(nacertos + 1) : 1;
    endfunction

    // Bits needed to hold the remaining-ticks value from 0 up to ticks.
    function automatic int largura_tempo(input int ticks);
        return (ticks > 0) ? $clog2(ticks + 1) : 1;
    endfunction

endpackage

// File: rtl/motor_rodada_contador_pisca.sv
// Blink sequencer: after a start pulse it produces NPISCA blinks, each
// BLINK_ON cycles lit followed by BLINK_OFF cycles dark. fim pulses on the
// last dark cycle, so the whole sequence lasts NPISCA*(BLINK_ON+BLINK_OFF).
module contador_pisca #(
    parameter int BLINK_ON  = 500,
    parameter int BLINK_OFF = 500,
    parameter int NPISCA    = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic aceso,
    output logic fim
);

    localparam int BMAX = (BLINK_ON > BLINK_OFF) ? BLINK_ON : BLINK_OFF;
    localparam int CW   = (BMAX > 1) ? $clog2(BMAX) : 1;
    localparam int PW   = (NPISCA > 1) ? $clog2(NPISCA) : 1;

    localparam logic [CW-1:0] ULT_ON    = CW'(BLINK_ON - 1);
    localparam logic [CW-1:0] ULT_OFF   = CW'(BLINK_OFF - 1);
    localparam logic [PW-1:0] ULT_PISCA = PW'(NPISCA - 1);

    logic          ativo_q, ativo_d;
    logic          fase_on_q, fase_on_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pisca_q, pisca_d;
    logic          ultimo_off;

    // Next-state of the ON/OFF phase counter and the blink counter.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        ativo_d    = ativo_q;
        fase_on_d  = fase_on_q;
        cnt_d      = cnt_q;
        pisca_d    = pisca_q;
        ultimo_off = 1'b0;
        if (start) begin
            ativo_d   = 1'b1;
            fase_on_d = 1'b1;
            cnt_d     = '0;
            pisca_d   = '0;
        end else if (ativo_q) begin
            if (fase_on_q) begin
                if (cnt_q == ULT_ON) begin
                    fase_on_d = 1'b0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                if (cnt_q == ULT_OFF) begin
                    cnt_d = '0;
                    if (pisca_q == ULT_PISCA) begin
                        ativo_d    = 1'b0;
                        ultimo_off = 1'b1;
                    end else begin
                        pisca_d   = pisca_q + PW'(1);
                        fase_on_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    // Sequencer registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            ativo_q   <= 1'b0;
            fase_on_q <= 1'b0;
            cnt_q     <= '0;
            pisca_q   <= '0;
        end else begin
            ativo_q   <= ativo_d;
            fase_on_q <= fase_on_d;
            cnt_q     <= cnt_d;
            pisca_q   <= pisca_d;
        end
    end

    assign aceso = ativo_q & fase_on_q;
    assign fim   = ultimo_off;

endmodule

// File: rtl/motor_rodada.sv
// Round engine of the LED memory game: loads each expected pattern from
// the pattern memory, blinks it, waits for a button play under a tick
// timeout and scores the play (optionally rejecting a repeated hit).
module motor_rodada
    import motor_rodada_pkg::*;
#(
    parameter int NBTN      = 4,
    parameter int SEQ_W     = 4,
    parameter int TIMEOUT   = 300,
    parameter int BLINK_ON  = 500,
    parameter int BLINK_OFF = 500,
    parameter int NPISCA    = 3,
    parameter int NACERTOS  = 3
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  iniciar,
    input  logic                                  nivel,
    input  logic                                  tick,
    input  logic [NBTN-1:0]                       botoes,
    output logic [SEQ_W-1:0]                      mem_addr,
    input  logic [NBTN-1:0]                       mem_data,
    output logic [NBTN-1:0]                       leds,
    output logic [largura_acertos(NACERTOS)-1:0]  acertos,
    output logic [largura_tempo(TIMEOUT)-1:0]     tempo_restante,
    output logic                                  fim_rodada,
    output logic                                  vitoria,
    output logic                                  timeout,
    output logic [2:0]                            db_estado
);

    localparam int AW = largura_acertos(NACERTOS);
    localparam int TW = largura_tempo(TIMEOUT);

    localparam logic [AW-1:0] META       = AW'(NACERTOS);
    localparam logic [TW-1:0] TEMPO_MAX  = TW'(TIMEOUT);

    estado_t          estado_q, estado_d;
    logic [SEQ_W-1:0] mem_addr_q, mem_addr_d;
    logic [NBTN-1:0]  esperado_q, esperado_d;
    logic [NBTN-1:0]  jogada_q, jogada_d;
    logic [NBTN-1:0]  acerto_ant_q, acerto_ant_d;
    logic [AW-1:0]    acertos_q, acertos_d;
    logic [TW-1:0]    tempo_q, tempo_d;
    logic             fim_q, fim_d;
    logic             vitoria_q, vitoria_d;
    logic             timeout_q, timeout_d;
    logic             nivel_q, nivel_d;
    logic             fase_q, fase_d;
    logic             btn_or_q, btn_or_d;

    logic             borda;
    logic             acerto;
    logic [AW-1:0]    novo_acertos;
    logic             inicia_pisca;
    logic             pisca_aceso;
    logic             pisca_fim;

    contador_pisca #(
        .BLINK_ON  (BLINK_ON),
        .BLINK_OFF (BLINK_OFF),
        .NPISCA    (NPISCA)
    ) u_pisca (
        .clock (clock),
        .reset (reset),
        .start (inicia_pisca),
        .aceso (pisca_aceso),
        .fim   (pisca_fim)
    );

    // Press detection: rising edge of "any button" against last cycle's OR,
    // so a button already held when ESPERA is entered does not count.
    assign borda = (|botoes) & ~btn_or_q;

    // Hit rule; hard mode also forbids repeating the previous correct play.
    assign acerto = (jogada_q == esperado_q) && (jogada_q != '0) &&
                    !(nivel_q && (jogada_q == acerto_ant_q));
    assign novo_acertos = acerto ? (acertos_q + AW'(1)) : acertos_q;

    // Round FSM plus its datapath next-state.
    always_comb begin
        estado_d     = estado_q;
        mem_addr_d   = mem_addr_q;
        esperado_d   = esperado_q;
        jogada_d     = jogada_q;
        acerto_ant_d = acerto_ant_q;
        acertos_d    = acertos_q;
        tempo_d      = tempo_q;
        fim_d        = fim_q;
        vitoria_d    = vitoria_q;
        timeout_d    = timeout_q;
        nivel_d      = nivel_q;
        fase_d       = 1'b0;
        btn_or_d     = |botoes;
        inicia_pisca = 1'b0;
        case (estado_q)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    estado_d     = CARREGA;
                    mem_addr_d   = '0;
                    acertos_d    = '0;
                    acerto_ant_d = '0;
                    fim_d        = 1'b0;
                    vitoria_d    = 1'b0;
                    timeout_d    = 1'b0;
                    nivel_d      = nivel;
                end
            end
            CARREGA: begin
                // First cycle lets the memory respond to the new address;
                // the second captures its data.
                if (!fase_q) begin
                    fase_d = 1'b1;
                end else begin
                    esperado_d   = mem_data;
                    inicia_pisca = 1'b1;
                    estado_d     = MOSTRA;
                end
            end
            MOSTRA: begin
                if (pisca_fim) begin
                    estado_d = ESPERA;
                    tempo_d  = TEMPO_MAX;
                end
            end
            ESPERA: begin
                // A press on the final tick's cycle wins over the timeout.
                if (borda) begin
                    estado_d = REGISTRA;
                end else if (tick && (tempo_q != '0)) begin
                    tempo_d = tempo_q - TW'(1);
                    if (tempo_q == TW'(1)) begin
                        estado_d  = FIM;
                        fim_d     = 1'b1;
                        timeout_d = 1'b1;
                        vitoria_d = 1'b0;
                    end
                end
            end
            REGISTRA: begin
                jogada_d = botoes;
                estado_d = COMPARA;
            end
            COMPARA: begin
                if (acerto) begin
                    acertos_d    = novo_acertos;
                    acerto_ant_d = jogada_q;
                end
                if (novo_acertos == META) begin
                    estado_d  = FIM;
                    fim_d     = 1'b1;
                    vitoria_d = 1'b1;
                end else if (&mem_addr_q) begin
                    // End of the sequence: the address never wraps.
                    estado_d  = FIM;
                    fim_d     = 1'b1;
                    vitoria_d = 1'b0;
                end else begin
                    mem_addr_d = mem_addr_q + SEQ_W'(1);
                    estado_d   = CARREGA;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= OCIOSO;
            mem_addr_q   <= '0;
            esperado_q   <= '0;
            jogada_q     <= '0;
            acerto_ant_q <= '0;
            acertos_q    <= '0;
            tempo_q      <= TEMPO_MAX;
            fim_q        <= 1'b0;
            vitoria_q    <= 1'b0;
            timeout_q    <= 1'b0;
            nivel_q      <= 1'b0;
            fase_q       <= 1'b0;
            btn_or_q     <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            mem_addr_q   <= mem_addr_d;
            esperado_q   <= esperado_d;
            jogada_q     <= jogada_d;
            acerto_ant_q <= acerto_ant_d;
            acertos_q    <= acertos_d;
            tempo_q      <= tempo_d;
            fim_q        <= fim_d;
            vitoria_q    <= vitoria_d;
            timeout_q    <= timeout_d;
            nivel_q      <= nivel_d;
            fase_q       <= fase_d;
            btn_or_q     <= btn_or_d;
        end
    end

    assign leds           = ((estado_q == MOSTRA) && pisca_aceso) ? esperado_q : '0;
    assign mem_addr       = mem_addr_q;
    assign acertos        = acertos_q;
    assign tempo_restante = tempo_q;
    assign fim_rodada     = fim_q;
    assign vitoria        = vitoria_q;
    assign timeout        = timeout_q;
    assign db_estado      = estado_q;

endmodule
